tx_frame_arbiter: RTL

Shares the single MAC transmit path among N upper-layer frame sources (ARP reply, ICMP echo reply, UDP tx, TCP tx). It picks the next source with packet-granular round-robin arbitration and locks the grant for a whole frame. It forwards that source's op_st/op/op_end/data stream to the MAC through one register stage. It then enforces an inter-frame idle gap and recovers from sources that are granted but never start.

---
 rtl/tx_arb_pkg.sv | 28 ++
 rtl/tx_frame_arbiter_rr_pick.sv | 32 +++
 rtl/tx_frame_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types, widths and helper functions for the MAC transmit arbiter.
package tx_arb_pkg;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) r = b + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_frame_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester at or after the pointer, wrapping modulo N_REQ.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_j = IDX_W'((int'(i_ptr) + i) % N_REQ);
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Packet-granular round-robin arbiter sharing one MAC transmit path among N_REQ frame sources,
// with a one-register forwarding stage, start timeout and enforced inter-frame gap.
//
// state | meaning
// IDLE  | waiting for a request while the MAC is free
// GRANT | source granted, start timer running until op_st or timeout
// XFER  | forwarding granted source until op_end
// GAP   | IFG_CYC+1 idle cycles before the next arbitration
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int START_TMO = 64,
    parameter int IFG_CYC   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        op_st_i,
    input  logic [N_REQ-1:0]        op_i,
    input  logic [N_REQ-1:0]        op_end_i,
    input  logic [DATA_W*N_REQ-1:0] data_i,
    input  logic [LEN_W*N_REQ-1:0]  len_i,
    input  logic                    mac_busy_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic                    mac_op_st_o,
    output logic                    mac_op_o,
    output logic                    mac_op_end_o,
    output logic [DATA_W-1:0]       mac_data_o,
    output logic [LEN_W-1:0]        mac_len_o,
    output logic [2:0]              active_id_o,
    output logic                    timeout_o
);

    localparam int IDX_W   = idx_w(N_REQ);
    localparam int CNT_MAX = (START_TMO > IFG_CYC + 1) ? START_TMO : IFG_CYC + 1;
    localparam int CNT_W   = clog2(CNT_MAX + 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [N_REQ-1:0]   r_gnt;

    logic [N_REQ-1:0]   w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;

    logic               w_sel_st;
    logic               w_sel_op;
    logic               w_sel_end;
    logic [DATA_W-1:0]  w_sel_data;
    logic [LEN_W-1:0]   w_sel_len;

    logic               w_grant_now;
    logic               w_fwd;
    logic               w_acc_st;
    logic               w_acc_end;
    logic               w_tmo;

    logic               r_mac_st;
    logic               r_mac_op;
    logic               r_mac_end;
    logic [DATA_W-1:0]  r_mac_data;
    logic [LEN_W-1:0]   r_mac_len;
    logic               r_tmo;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Only the granted source is ever looked at; everything else is dropped here.
    always_comb begin
        w_sel_st   = 1'b0;
        w_sel_op   = 1'b0;
        w_sel_end  = 1'b0;
        w_sel_data = '0;
        w_sel_len  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel_st   = op_st_i[k];
                w_sel_op   = op_i[k];
                w_sel_end  = op_end_i[k];
                w_sel_data = data_i[k*DATA_W +: DATA_W];
                w_sel_len  = len_i[k*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_now = 1'b0;
        w_fwd       = 1'b0;
        w_acc_st    = 1'b0;
        w_acc_end   = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!mac_busy_i && w_pick_any) begin
                    w_grant_now = 1'b1;
                    w_cnt_nxt   = CNT_W'(START_TMO - 1);
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_sel_op && w_sel_st) begin
                    w_fwd    = 1'b1;
                    w_acc_st = 1'b1;
                    if (w_sel_end) begin
                        w_acc_end   = 1'b1;
                        w_cnt_nxt   = CNT_W'(IFG_CYC);
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = XFER;
                    end
                end else if (r_cnt == '0) begin
                    w_tmo       = 1'b1;
                    w_cnt_nxt   = CNT_W'(IFG_CYC);
                    w_state_nxt = GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            XFER: begin
                if (w_sel_op) begin
                    w_fwd = 1'b1;
                    if (w_sel_end) begin
                        w_acc_end   = 1'b1;
                        w_cnt_nxt   = CNT_W'(IFG_CYC);
                        w_state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pointer advances at grant time, so a timed-out source also loses its turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt <= '0;
            r_idx <= '0;
            r_ptr <= '0;
        end else if (w_grant_now) begin
            r_gnt <= w_pick_gnt;
            r_idx <= w_pick_idx;
            if (w_pick_idx == IDX_W'(N_REQ - 1)) r_ptr <= '0;
            else                                 r_ptr <= w_pick_idx + 1'b1;
        end else if (w_state_nxt == GAP) begin
            r_gnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mac_st   <= 1'b0;
            r_mac_op   <= 1'b0;
            r_mac_end  <= 1'b0;
            r_mac_data <= '0;
            r_mac_len  <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_mac_st   <= w_acc_st;
            r_mac_op   <= w_fwd;
            r_mac_end  <= w_acc_end;
            r_mac_data <= w_fwd ? w_sel_data : '0;
            r_tmo      <= w_tmo;
            if (w_acc_st) r_mac_len <= w_sel_len;
        end
    end

    assign gnt_o        = r_gnt;
    assign mac_op_st_o  = r_mac_st;
    assign mac_op_o     = r_mac_op;
    assign mac_op_end_o = r_mac_end;
    assign mac_data_o   = r_mac_data;
    assign mac_len_o    = r_mac_len;
    assign active_id_o  = 3'(r_idx);
    assign timeout_o    = r_tmo;

endmodule
